// File: rtl/bp_pkg.sv
// Shared encodings for the branch predictor: 2-bit counter states, FSM states
// and the saturating-counter step function.
package bp_pkg;

  localparam int IDX_W_DEF = 3;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } bp_state_e;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic inc, input logic dec);
    logic [1:0] n;
    n = c;
    if (inc && c != CTR_ST) n = c + 2'd1;
    else if (dec && c != CTR_SNT) n = c - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/bp_sat_ctr2.sv
// One BHT entry: 2-bit saturating counter, reset to weakly-not-taken.
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] ctr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctr <= CTR_WNT;
    else if (en) ctr <= ctr_step(ctr, inc, dec);
  end

endmodule

// File: rtl/bht_branch_ctrl.sv
// Branch history table predictor with one outstanding branch and hit/miss stats.
//   state | meaning
//   IDLE  | no unresolved branch
//   PEND  | one branch captured, waiting for its resolution in ID
module bht_branch_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_IF,
  input  logic [31:0]       pc_IF,
  input  logic [31:0]       PC_add_4,
  input  logic [31:0]       PC_add_imm,
  input  logic              branch_ID,
  input  logic              jump_or_not,
  output logic [31:0]       PC_out,
  output logic              predict_jump,
  output logic              correct,
  output logic              flush,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt
);

  localparam int BHT_N = 1 << IDX_W;

  bp_state_e        state_q;
  logic [IDX_W-1:0] sv_idx;
  logic             sv_pred;
  logic [31:0]      sv_pc4;
  logic [31:0]      sv_imm;
  logic [1:0]       ctr_q [BHT_N];

  logic [IDX_W-1:0] idx;
  logic             resolve;
  logic             mispredict;
  logic             lookup;

  wire unused_pc = ^{pc_IF[31:IDX_W+2], pc_IF[1:0]};

  assign idx = pc_IF[IDX_W+1:2];

  for (genvar i = 0; i < BHT_N; i++) begin : g_bht
    bp_sat_ctr2 u_ctr (
      .clk (clk),
      .rst (rst),
      .en  (resolve && sv_idx == IDX_W'(i)),
      .inc (jump_or_not),
      .dec (~jump_or_not),
      .ctr (ctr_q[i])
    );
  end

  // Outputs are combinational so the fetch redirect lands in the same cycle.
  always_comb begin
    resolve      = ~rst && ~stall && branch_ID && (state_q == PEND);
    mispredict   = resolve && (sv_pred != jump_or_not);
    lookup       = ~rst && ~stall && branch_IF && ~mispredict;
    predict_jump = lookup && ctr_q[idx][1];
    correct      = ~mispredict;
    flush        = mispredict;
    if (mispredict)        PC_out = jump_or_not ? sv_imm : sv_pc4;
    else if (predict_jump) PC_out = PC_add_imm;
    else                   PC_out = PC_add_4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sv_idx  <= '0;
      sv_pred <= 1'b0;
      sv_pc4  <= '0;
      sv_imm  <= '0;
    end else if (!stall) begin
      if (mispredict) begin
        state_q <= IDLE;
      end else if (lookup) begin
        state_q <= PEND;
        sv_idx  <= idx;
        sv_pred <= predict_jump;
        sv_pc4  <= PC_add_4;
        sv_imm  <= PC_add_imm;
      end else if (resolve) begin
        state_q <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (resolve) begin
      if (mispredict) begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + STAT_W'(1);
      end else begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bht_branch_ctrl.sv
// Directed bench for bht_branch_ctrl: prediction, resolution, stall and async reset.
module tb_bht_branch_ctrl;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_IF;
  logic [31:0] pc_IF;
  logic [31:0] PC_add_4;
  logic [31:0] PC_add_imm;
  logic        branch_ID;
  logic        jump_or_not;
  logic [31:0] PC_out;
  logic        predict_jump;
  logic        correct;
  logic        flush;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bht_branch_ctrl #(.IDX_W(3), .STAT_W(16)) dut (
    .clk (clk), .rst (rst), .stall (stall),
    .branch_IF (branch_IF), .pc_IF (pc_IF), .PC_add_4 (PC_add_4), .PC_add_imm (PC_add_imm),
    .branch_ID (branch_ID), .jump_or_not (jump_or_not),
    .PC_out (PC_out), .predict_jump (predict_jump), .correct (correct), .flush (flush),
    .hit_cnt (hit_cnt), .miss_cnt (miss_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_if(input logic br, input logic [31:0] pc, input logic [31:0] p4, input logic [31:0] imm);
    branch_IF  = br;
    pc_IF      = pc;
    PC_add_4   = p4;
    PC_add_imm = imm;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; branch_ID = 1'b0; jump_or_not = 1'b0;
    drive_if(1'b0, 32'h0, 32'h44, 32'h80);
    #2;
    n_chk++; if (PC_out !== 32'h44) begin n_fail++; $display("FAIL reset_pc: got %h exp 44", PC_out); end
    n_chk++; if (predict_jump !== 1'b0 || correct !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL reset_flags: pj=%b c=%b f=%b exp 0 1 0", predict_jump, correct, flush); end
    n_chk++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stats: hit=%0d miss=%0d exp 0 0", hit_cnt, miss_cnt); end
    n_chk++; if (dut.ctr_q[0] !== 2'b01 || dut.ctr_q[7] !== 2'b01) begin n_fail++; $display("FAIL reset_ctr: e0=%b e7=%b exp 01", dut.ctr_q[0], dut.ctr_q[7]); end
    n_chk++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d exp IDLE", dut.state_q); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_first_predict();
    drive_if(1'b1, 32'h40, 32'h44, 32'h80);
    #2;
    n_chk++; if (predict_jump !== 1'b0) begin n_fail++; $display("FAIL first_pred: got %b exp 0", predict_jump); end
    n_chk++; if (PC_out !== 32'h44) begin n_fail++; $display("FAIL first_pc: got %h exp 44", PC_out); end
    tick();
    branch_IF = 1'b0;
    n_chk++; if (dut.state_q !== PEND) begin n_fail++; $display("FAIL first_state: got %0d exp PEND", dut.state_q); end
  endtask

  task automatic test_mispredict();
    branch_ID = 1'b1; jump_or_not = 1'b1;
    #2;
    n_chk++; if (correct !== 1'b0 || flush !== 1'b1) begin n_fail++; $display("FAIL misp_flags: c=%b f=%b exp 0 1", correct, flush); end
    n_chk++; if (PC_out !== 32'h80) begin n_fail++; $display("FAIL misp_pc: got %h exp 80", PC_out); end
    tick();
    branch_ID = 1'b0;
    n_chk++; if (dut.ctr_q[0] !== 2'b10) begin n_fail++; $display("FAIL misp_ctr: got %b exp 10", dut.ctr_q[0]); end
    n_chk++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin n_fail++; $display("FAIL misp_stats: hit=%0d miss=%0d exp 0 1", hit_cnt, miss_cnt); end
    n_chk++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL misp_state: got %0d exp IDLE", dut.state_q); end
  endtask

  task automatic test_correct_predict();
    drive_if(1'b1, 32'h40, 32'h44, 32'h80);
    #2;
    n_chk++; if (predict_jump !== 1'b1 || PC_out !== 32'h80) begin n_fail++; $display("FAIL hit_pred: pj=%b pc=%h exp 1 80", predict_jump, PC_out); end
    tick();
    branch_IF = 1'b0; branch_ID = 1'b1; jump_or_not = 1'b1;
    #2;
    n_chk++; if (correct !== 1'b1 || flush !== 1'b0 || PC_out !== 32'h44) begin n_fail++; $display("FAIL hit_resolve: c=%b f=%b pc=%h exp 1 0 44", correct, flush, PC_out); end
    tick();
    branch_ID = 1'b0;
    n_chk++; if (dut.ctr_q[0] !== 2'b11 || hit_cnt !== 16'd1) begin n_fail++; $display("FAIL hit_update: ctr=%b hit=%0d exp 11 1", dut.ctr_q[0], hit_cnt); end
    branch_IF = 1'b1;
    tick();
    branch_IF = 1'b0; branch_ID = 1'b1; jump_or_not = 1'b1;
    tick();
    branch_ID = 1'b0;
    n_chk++; if (dut.ctr_q[0] !== 2'b11) begin n_fail++; $display("FAIL sat_high: got %b exp 11", dut.ctr_q[0]); end
    n_chk++; if (hit_cnt !== 16'd2 || miss_cnt !== 16'd1) begin n_fail++; $display("FAIL sat_stats: hit=%0d miss=%0d exp 2 1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_back_to_back();
    drive_if(1'b1, 32'h40, 32'h44, 32'h80);
    tick();
    drive_if(1'b1, 32'h44, 32'h48, 32'h100);
    branch_ID = 1'b1; jump_or_not = 1'b1;
    #2;
    n_chk++; if (correct !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL b2b_flags: c=%b f=%b exp 1 0", correct, flush); end
    n_chk++; if (predict_jump !== 1'b0 || PC_out !== 32'h48) begin n_fail++; $display("FAIL b2b_pred: pj=%b pc=%h exp 0 48", predict_jump, PC_out); end
    tick();
    branch_IF = 1'b0;
    n_chk++; if (dut.state_q !== PEND || hit_cnt !== 16'd3) begin n_fail++; $display("FAIL b2b_capture: st=%0d hit=%0d exp PEND 3", dut.state_q, hit_cnt); end
    jump_or_not = 1'b0;
    #2;
    n_chk++; if (correct !== 1'b1) begin n_fail++; $display("FAIL b2b_second: c=%b exp 1", correct); end
    tick();
    branch_ID = 1'b0;
    n_chk++; if (dut.ctr_q[1] !== 2'b00 || hit_cnt !== 16'd4) begin n_fail++; $display("FAIL b2b_update: ctr1=%b hit=%0d exp 00 4", dut.ctr_q[1], hit_cnt); end
    n_chk++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL b2b_state: got %0d exp IDLE", dut.state_q); end
  endtask

  task automatic test_mispredict_with_if();
    drive_if(1'b1, 32'h40, 32'h44, 32'h80);
    tick();
    drive_if(1'b1, 32'h48, 32'h4c, 32'h200);
    branch_ID = 1'b1; jump_or_not = 1'b0;
    #2;
    n_chk++; if (correct !== 1'b0 || flush !== 1'b1) begin n_fail++; $display("FAIL mif_flags: c=%b f=%b exp 0 1", correct, flush); end
    n_chk++; if (predict_jump !== 1'b0 || PC_out !== 32'h44) begin n_fail++; $display("FAIL mif_pc: pj=%b pc=%h exp 0 44", predict_jump, PC_out); end
    tick();
    branch_IF = 1'b0;
    n_chk++; if (dut.state_q !== IDLE || dut.ctr_q[0] !== 2'b10 || miss_cnt !== 16'd2) begin n_fail++; $display("FAIL mif_after: st=%0d ctr0=%b miss=%0d exp IDLE 10 2", dut.state_q, dut.ctr_q[0], miss_cnt); end
    jump_or_not = 1'b1;
    #2;
    n_chk++; if (correct !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL idle_resolve: c=%b f=%b exp 1 0", correct, flush); end
    tick();
    branch_ID = 1'b0;
    n_chk++; if (dut.ctr_q[2] !== 2'b01 || dut.ctr_q[0] !== 2'b10) begin n_fail++; $display("FAIL idle_noupd: ctr2=%b ctr0=%b exp 01 10", dut.ctr_q[2], dut.ctr_q[0]); end
    n_chk++; if (hit_cnt !== 16'd4 || miss_cnt !== 16'd2) begin n_fail++; $display("FAIL idle_stats: hit=%0d miss=%0d exp 4 2", hit_cnt, miss_cnt); end
  endtask

  task automatic test_stall();
    drive_if(1'b1, 32'h40, 32'h44, 32'h80);
    #2;
    n_chk++; if (predict_jump !== 1'b1) begin n_fail++; $display("FAIL stall_pre: pj=%b exp 1", predict_jump); end
    tick();
    drive_if(1'b1, 32'h40, 32'h60, 32'h90);
    stall = 1'b1; branch_ID = 1'b1; jump_or_not = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      n_chk++; if (correct !== 1'b1 || flush !== 1'b0 || predict_jump !== 1'b0 || PC_out !== 32'h60) begin
        n_fail++; $display("FAIL stall_out[%0d]: c=%b f=%b pj=%b pc=%h exp 1 0 0 60", k, correct, flush, predict_jump, PC_out);
      end
      tick();
      n_chk++; if (dut.state_q !== PEND || dut.ctr_q[0] !== 2'b10 || hit_cnt !== 16'd4 || miss_cnt !== 16'd2) begin
        n_fail++; $display("FAIL stall_hold[%0d]: st=%0d ctr0=%b hit=%0d miss=%0d exp PEND 10 4 2", k, dut.state_q, dut.ctr_q[0], hit_cnt, miss_cnt);
      end
    end
    stall = 1'b0; branch_IF = 1'b0;
    #2;
    n_chk++; if (correct !== 1'b0 || flush !== 1'b1 || PC_out !== 32'h44) begin n_fail++; $display("FAIL stall_release: c=%b f=%b pc=%h exp 0 1 44", correct, flush, PC_out); end
    tick();
    branch_ID = 1'b0;
    n_chk++; if (dut.ctr_q[0] !== 2'b01 || miss_cnt !== 16'd3 || dut.state_q !== IDLE) begin n_fail++; $display("FAIL stall_after: ctr0=%b miss=%0d st=%0d exp 01 3 IDLE", dut.ctr_q[0], miss_cnt, dut.state_q); end
  endtask

  task automatic test_async_reset();
    drive_if(1'b1, 32'h40, 32'h44, 32'h80);
    tick();
    branch_IF = 1'b0; branch_ID = 1'b1; jump_or_not = 1'b1;
    #2;
    n_chk++; if (flush !== 1'b1) begin n_fail++; $display("FAIL arst_pre: f=%b exp 1", flush); end
    rst = 1'b1;
    #1;
    n_chk++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL arst_state: got %0d exp IDLE", dut.state_q); end
    n_chk++; if (flush !== 1'b0 || correct !== 1'b1 || predict_jump !== 1'b0 || PC_out !== 32'h44) begin n_fail++; $display("FAIL arst_out: f=%b c=%b pj=%b pc=%h exp 0 1 0 44", flush, correct, predict_jump, PC_out); end
    n_chk++; if (dut.ctr_q[0] !== 2'b01 || dut.ctr_q[1] !== 2'b01) begin n_fail++; $display("FAIL arst_ctr: e0=%b e1=%b exp 01 01", dut.ctr_q[0], dut.ctr_q[1]); end
    n_chk++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_stats: hit=%0d miss=%0d exp 0 0", hit_cnt, miss_cnt); end
    #1;
    rst = 1'b0;
    tick();
    branch_ID = 1'b0;
    n_chk++; if (dut.ctr_q[0] !== 2'b01 || miss_cnt !== 16'd0 || dut.state_q !== IDLE) begin n_fail++; $display("FAIL arst_after: ctr0=%b miss=%0d st=%0d exp 01 0 IDLE", dut.ctr_q[0], miss_cnt, dut.state_q); end
  endtask

  initial begin
    test_reset();
    test_first_predict();
    test_mispredict();
    test_correct_predict();
    test_back_to_back();
    test_mispredict_with_if();
    test_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
